// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, redirect flush, RAW/load-use stall.
// Define HAZARD_CTRL_FORWARDING_EN to enable EX operand forwarding.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rs1_ex,
  input  logic [4:0] rs2_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rd_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_write_ex,
  input  logic       reg_write_mem,
  input  logic       reg_write_wb,
  input  logic       load_ex,
  input  logic       load_mem,
  input  logic       store_mem,
  input  logic [1:0] next_pc_selector_mem,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic       pc_redirect,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       halted
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic mem_busy;
  logic ex_dep;
  logic mem_dep;
  logic lu_hit;
  logic raw_hit;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign mem_busy = (load_mem | store_mem) & ~dmem_ready;

  assign ex_dep = reg_write_ex & (rd_ex != 5'd0) &
                  ((use_rs1_id & (rs1_id == rd_ex)) |
                   (use_rs2_id & (rs2_id == rd_ex)));

  assign mem_dep = reg_write_mem & (rd_mem != 5'd0) &
                   ((use_rs1_id & (rs1_id == rd_mem)) |
                    (use_rs2_id & (rs2_id == rd_mem)));

  assign lu_hit = load_ex & ex_dep;

`ifdef HAZARD_CTRL_FORWARDING_EN
  logic unused_dep;
  assign unused_dep = mem_dep;
  assign raw_hit = lu_hit;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs1_ex)
      fwd_a = 2'b10;
    else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs1_ex)
      fwd_a = 2'b01;
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs2_ex)
      fwd_b = 2'b10;
    else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs2_ex)
      fwd_b = 2'b01;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_ex, rs2_ex, rd_wb, reg_write_wb};
  assign raw_hit = lu_hit | ex_dep | mem_dep;
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    logic hold;
    logic resolve;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold        = 1'b0;
    resolve     = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    pc_redirect = 1'b0;
    forward_a   = fwd_a;
    forward_b   = fwd_b;
    halted      = 1'b0;

    unique case (state_q)
      RUN: begin
        cnt_d = 8'd0;
        if (mem_busy) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = 8'd1;
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          cnt_d   = 8'd0;
          resolve = 1'b1;
        end else begin
          hold = 1'b1;
          if (cnt_q >= LAST) state_d = HALT;
          else cnt_d = cnt_q + 8'd1;
        end
      end
      HALT: begin
        hold   = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase

    if (hold) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end

    // Access just completed: lower-priority events act this cycle
    if (resolve) begin
      if (next_pc_selector_mem != 2'b00) begin
        pc_redirect = 1'b1;
        flush_id    = 1'b1;
        flush_ex    = 1'b1;
        flush_mem   = 1'b1;
      end else if (raw_hit) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end

    if (!rst_n) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      bubble_ex   = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      flush_mem   = 1'b0;
      pc_redirect = 1'b0;
      forward_a   = 2'b00;
      forward_b   = 2'b00;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors, expected outputs queued,
// monitor pops and compares on each falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex;
  logic [4:0] rd_ex, rd_mem, rd_wb;
  logic       use_rs1_id, use_rs2_id;
  logic       reg_write_ex, reg_write_mem, reg_write_wb;
  logic       load_ex, load_mem, store_mem;
  logic [1:0] next_pc_selector_mem;
  logic       dmem_ready;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       bubble_ex, flush_id, flush_ex, flush_mem;
  logic       pc_redirect, halted;
  logic [1:0] forward_a, forward_b;

  int tests  = 0;
  int failed = 0;

  logic [13:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem),
    .reg_write_wb(reg_write_wb),
    .load_ex(load_ex), .load_mem(load_mem), .store_mem(store_mem),
    .next_pc_selector_mem(next_pc_selector_mem),
    .dmem_ready(dmem_ready),
    .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .flush_ex(flush_ex), .flush_mem(flush_mem),
    .pc_redirect(pc_redirect),
    .forward_a(forward_a), .forward_b(forward_b),
    .halted(halted)
  );

  // {stall_if,id,ex,mem, bubble, flush_id,ex,mem, redirect, fa, fb, halted}
  function automatic logic [13:0] mk(
    logic sf, logic sb, logic bub, logic fl,
    logic [1:0] fa, logic [1:0] fb, logic h);
    return {sf, sf, sb, sb, bub, fl, fl, fl, fl, fa, fb, h};
  endfunction

  localparam logic [13:0] Z  = 14'd0;
  localparam logic [13:0] ST = {4'b1111, 10'd0};
  localparam logic [13:0] LU = {4'b1100, 1'b1, 9'd0};
  localparam logic [13:0] RD = {5'd0, 4'b1111, 5'd0};
  localparam logic [13:0] HL = {4'b1111, 9'd0, 1'b1};

`ifdef HAZARD_CTRL_FORWARDING_EN
  localparam logic [13:0] RAW = Z;
`else
  localparam logic [13:0] RAW = LU;
`endif

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
           flush_id, flush_ex, flush_mem, pc_redirect,
           forward_a, forward_b, halted};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL %s: got %b want %b", n, a, e);
      end
    end
  end

  task automatic clr();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0;
    rd_ex = 0; rd_mem = 0; rd_wb = 0;
    use_rs1_id = 0; use_rs2_id = 0;
    reg_write_ex = 0; reg_write_mem = 0; reg_write_wb = 0;
    load_ex = 0; load_mem = 0; store_mem = 0;
    next_pc_selector_mem = 0; dmem_ready = 0;
  endtask

  task automatic apply(string n, logic [13:0] e);
    name_q.push_back(n);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    load_ex = 1; reg_write_ex = 1; rd_ex = 5;
    rs2_id = 5; use_rs2_id = 1;
  endtask

  initial begin
    rst_n = 0;
    clr();
    @(posedge clk);
    #1;

    load_mem = 1; next_pc_selector_mem = 2; set_lu();
    apply("reset_outputs_zero", Z);
    rst_n = 1; clr();
    apply("idle", Z);

    load_mem = 1;
    apply("ld_wait1", ST);
    apply("ld_wait2", ST);
    apply("ld_wait3", ST);
    dmem_ready = 1;
    apply("ld_ready", Z);
    clr(); next_pc_selector_mem = 2;
    apply("run_after_ld", RD);

    clr(); load_mem = 1; dmem_ready = 1;
    apply("zero_wait", Z);
    clr(); next_pc_selector_mem = 1;
    apply("run_after_zw", RD);

    clr(); store_mem = 1;
    apply("rst_mw_a", ST);
    apply("rst_mw_b", ST);
    rst_n = 0;
    apply("rst_mw_reset", Z);
    rst_n = 1; clr();
    apply("rst_mw_idle", Z);
    next_pc_selector_mem = 3;
    apply("rst_mw_run", RD);

    clr(); store_mem = 1;
    apply("to_stall1", ST);
    apply("to_stall2", ST);
    apply("to_stall3", ST);
    apply("to_stall4", ST);
    apply("halt_a", HL);
    dmem_ready = 1;
    apply("halt_ign_ready", HL);
    store_mem = 0; next_pc_selector_mem = 2;
    apply("halt_no_redir", HL);
    rst_n = 0;
    apply("halt_reset", Z);
    rst_n = 1; clr();
    apply("halt_cleared", Z);

    set_lu();
    apply("load_use", LU);
    clr();
    apply("load_use_once", Z);
    set_lu(); next_pc_selector_mem = 2;
    apply("redir_over_lu", RD);
    clr(); set_lu(); rd_ex = 0; rs2_id = 0;
    apply("lu_rd0", Z);
    clr(); set_lu(); use_rs2_id = 0;
    apply("lu_unused_src", Z);

    clr(); set_lu(); next_pc_selector_mem = 2; load_mem = 1;
    apply("mem_over_all", ST);
    clr(); dmem_ready = 1;
    apply("mw_release", Z);

    clr(); reg_write_ex = 1; rd_ex = 3;
    rs1_id = 3; use_rs1_id = 1;
    apply("raw_ex", RAW);
    clr(); reg_write_mem = 1; rd_mem = 9;
    rs2_id = 9; use_rs2_id = 1;
    apply("raw_mem", RAW);
    clr(); reg_write_mem = 1; use_rs2_id = 1;
    apply("raw_rd0", Z);

    clr(); rs1_ex = 7; rs2_ex = 7; rd_mem = 7; rd_wb = 7;
    reg_write_mem = 1; reg_write_wb = 1;
`ifdef HAZARD_CTRL_FORWARDING_EN
    apply("fwd_mem", mk(0, 0, 0, 0, 2'b10, 2'b10, 0));
    rd_mem = 0;
    apply("fwd_wb", mk(0, 0, 0, 0, 2'b01, 2'b01, 0));
    reg_write_wb = 0;
    apply("fwd_none", Z);
    rd_mem = 4; rs2_ex = 4; reg_write_wb = 1;
    apply("fwd_mixed", mk(0, 0, 0, 0, 2'b01, 2'b10, 0));
`else
    apply("fwd_off_a", Z);
    rd_mem = 0;
    apply("fwd_off_b", Z);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning max cycles waited for dmem_ready before halting (legal 2..255).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports rs1_id, rs2_id  in  5 each  source registers of the ID-stage instruction; use_rs1_id, use_rs2_id  in  1 each  source actually read.
REQ-005 SHALL have ports rs1_ex, rs2_ex  in  5 each  source registers of the EX-stage instruction.
REQ-006 SHALL have ports rd_ex, rd_mem, rd_wb  in  5 each; reg_write_ex, reg_write_mem, reg_write_wb  in  1 each  destination valid.
REQ-007 SHALL have ports load_ex, load_mem, store_mem  in  1 each; next_pc_selector_mem  in  2  nonzero means taken redirect resolved in MEM.
REQ-008 SHALL have port dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
REQ-009 SHALL have outputs stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC, IF/ID, ID/EX, EX/MEM registers.
REQ-010 SHALL have outputs bubble_ex, flush_id, flush_ex, flush_mem  out  1 each  load NOP into ID/EX, clear IF/ID, ID/EX, EX/MEM.
REQ-011 SHALL have outputs pc_redirect  out  1; forward_a, forward_b  out  2 each  EX operand source (00 RF, 01 MEM/WB, 10 EX/MEM); halted  out  1.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, HALT; outputs combinational from state and inputs.
REQ-013 SHALL, in RUN with (load_mem|store_mem) and !dmem_ready, assert stall_if, stall_id, stall_ex, stall_mem and go to MEM_WAIT; with dmem_ready high same cycle, no stall (zero-wait access).
REQ-014 SHALL, in MEM_WAIT, assert all four stalls, suppress flushes, bubbles and pc_redirect; wait counter increments each cycle.
REQ-015 SHALL, in MEM_WAIT on dmem_ready, deassert all stalls that cycle, clear counter, go to RUN.
REQ-016 SHALL, when counter reaches MEM_TIMEOUT-1 without dmem_ready, go to HALT; counter is 8 bits, cleared on every RUN entry.
REQ-017 SHALL, in HALT, assert all stalls and halted permanently until reset; dmem_ready ignored.
REQ-018 SHALL, in RUN with no memory stall and next_pc_selector_mem != 0, assert pc_redirect, flush_id, flush_ex, flush_mem for exactly that cycle.
REQ-019 SHALL detect load-use: load_ex & reg_write_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)); in RUN, assert stall_if, stall_id, bubble_ex for one cycle.
REQ-020 SHALL apply priority memory stall > redirect > load-use/RAW stall; a suppressed lower event is re-evaluated next cycle from current inputs.
REQ-021 SHALL never treat rd==0 as a hazard or forwarding source.

Reset
REQ-022 SHALL, while rst_n low at a clock edge, enter RUN, clear counter and halted; reset overrides MEM_WAIT and HALT mid-operation.
REQ-023 SHALL drive all outputs 0 during the reset cycle regardless of other inputs.

Configuration
REQ-024 SHALL honor macro HAZARD_CTRL_FORWARDING_EN.
REQ-025 SHALL, with the macro defined, set forward_a/b to 10 when reg_write_mem & rd_mem!=0 & rd_mem matches rs1_ex/rs2_ex, else 01 on reg_write_wb & rd_wb match, else 00; only load-use stalls.
REQ-026 SHALL, without the macro, tie forward_a/b to 00 and extend REQ-019 stalls to any RAW match of ID sources against rd_ex or rd_mem with reg_write set (loads or not).

Verification
REQ-027 SHALL check: load_mem=1, dmem_ready low 3 cycles then high -> stalls high 3 cycles, low on 4th, state RUN.
REQ-028 SHALL check: MEM_TIMEOUT=4, store_mem=1, dmem_ready never -> HALT after 4 stalled cycles, halted=1 until rst_n low for one edge.
REQ-029 SHALL check: load_ex=1, rd_ex=5, rs2_id=5, use_rs2_id=1 -> one cycle stall_if=stall_id=bubble_ex=1; same with next_pc_selector_mem=2 -> flushes and pc_redirect only.
REQ-030 SHALL check (FORWARDING_EN): rs1_ex=7, rd_mem=7, rd_wb=7, both reg_write -> forward_a=10; rd_mem=0 -> forward_a=01.
REQ-031 SHALL check (no FORWARDING_EN): reg_write_ex=1, rd_ex=3, rs1_id=3, use_rs1_id=1, load_ex=0 -> stall_if=1, forward_a=00.
